tristate_bus_arbiter: RTL



---
 rtl/tsb_pkg.sv | 48 ++++
 rtl/tristate_bus_arbiter_drv.sv | 14 +
 rtl/tristate_bus_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tsb_pkg.sv
// Shared types and arbitration helpers for the tristate bus arbiter.
package tsb_pkg;

    localparam int unsigned MAX_N = 16;
    localparam int unsigned PTR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } tsb_state_e;

    // One-hot winner: first set request scanning from ptr+1, wrapping at n.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0] req,
        input logic [PTR_W-1:0] ptr,
        input int unsigned      n
    );
        logic [MAX_N-1:0] pick;
        logic             found;
        logic [PTR_W:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(n)) begin
                idx = idx - (PTR_W+1)'(n);
            end
            if ((i <= n) && !found && req[idx[PTR_W-1:0]]) begin
                pick[idx[PTR_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_drv.sv
// W-bit bufif1-style driver: x/z data resolve to x when enabled, all-Z when disabled.
module tsb_drv #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] d,
    input  logic         oe,
    output tri   [W-1:0] q
);

    for (genvar b = 0; b < W; b++) begin : g_bit
        assign q[b] = oe ? ((d[b] === 1'b1) ? 1'b1 : ((d[b] === 1'b0) ? 1'b0 : 1'bx)) : 1'bz;
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with bounded tenure and an all-Z turnaround gap.
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        data,
    output tri   [W-1:0]          bus_out,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  owner,
    output logic                  busy,
    output logic                  turn
);

    localparam int unsigned OW     = $clog2(N);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned TURN_W = $clog2(TURN_CYC + 1);

    tsb_state_e        r_state, w_state_nxt;
    logic [N-1:0]      r_gnt, w_gnt_nxt;
    logic [OW-1:0]     r_owner, w_owner_nxt;
    logic [OW-1:0]     r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [TURN_W-1:0] r_tcnt, w_tcnt_nxt;
    logic              r_busy, r_turn;

    logic [N-1:0]      w_pick;
    logic [OW-1:0]     w_pick_idx;
    logic              w_grant;
    logic              w_own_req;
    logic              w_others;
    logic [W-1:0]      w_own_data;

    assign w_pick     = N'(rr_pick(MAX_N'(req), PTR_W'(r_ptr), N));
    assign w_pick_idx = OW'(onehot2idx(MAX_N'(w_pick)));
    assign w_own_req  = |(req & r_gnt);
    assign w_others   = |(req & ~r_gnt);

    // Next-state: release or pre-empt into TURN, arbitrate out of IDLE or the last TURN cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_tcnt_nxt  = r_tcnt;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant = |req;
            end
            ST_DRIVE: begin
                if (!w_own_req || ((r_hold == HOLD_W'(MAX_HOLD)) && w_others)) begin
                    w_state_nxt = ST_TURN;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_tcnt_nxt  = TURN_W'(TURN_CYC);
                end else if (r_hold != HOLD_W'(MAX_HOLD)) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                if (r_tcnt == TURN_W'(1)) begin
                    w_grant    = |req;
                    w_tcnt_nxt = '0;
                    if (!(|req)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt - TURN_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_grant) begin
            w_state_nxt = ST_DRIVE;
            w_gnt_nxt   = w_pick;
            w_owner_nxt = w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
            w_hold_nxt  = HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= OW'(N - 1);
            r_hold  <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b0;
            r_turn  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_busy  <= (w_state_nxt == ST_DRIVE);
            r_turn  <= (w_state_nxt == ST_TURN);
        end
    end

    // Only ownership is registered; the owner's data reaches the bus combinationally.
    assign w_own_data = data[r_owner*W +: W];

    tsb_drv #(
        .W (W)
    ) u_drv (
        .d  (w_own_data),
        .oe (r_busy),
        .q  (bus_out)
    );

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign turn  = r_turn;

endmodule
